// File: rtl/icap_pr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : icap_pr_ctrl
//  Purpose  : Sequencer between the decrypted bitstream word stream and the
//             ICAPE2 primitive. Discards pre-sync padding, detects the
//             7-series sync word, forwards the remaining words to ICAP with an
//             optional per-byte bit reversal, appends NOOP flush words, then
//             reports done or error. Stalled input is bounded by a timeout.
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             start/length_words - command pulse and total stream length
//             s_data/s_valid/
//             s_ready            - 32-bit input word stream handshake
//             icap_csib/rdwrb/i  - ICAPE2 write interface (registered)
//             busy/done/error/
//             err_code           - status (error is sticky until next start)
//             words_written      - stream words driven to ICAP (sync incl.)
//  Revision : 1.0 - initial release
// ============================================================================
module icap_pr_ctrl #(
  parameter int unsigned LEN_W          = 24,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned FLUSH_NOOPS    = 4,
  parameter int unsigned BITSWAP        = 1,
  parameter logic [31:0] SYNC_WORD      = 32'hAA995566
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] length_words,
  input  logic [31:0]      s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             icap_csib,
  output logic             icap_rdwrb,
  output logic [31:0]      icap_i,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [LEN_W-1:0] words_written
);

  localparam logic [31:0] c_NOOP     = 32'h2000_0000;
  // Idle counter only has to reach TIMEOUT_CYCLES-1; flush counter FLUSH_NOOPS-1.
  localparam int unsigned c_IDLE_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned c_FLUSH_W  = (FLUSH_NOOPS > 1) ? $clog2(FLUSH_NOOPS) : 1;

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_HUNT   = 3'd1;
  localparam logic [2:0] c_ST_STREAM = 3'd2;
  localparam logic [2:0] c_ST_FLUSH  = 3'd3;
  localparam logic [2:0] c_ST_DONE   = 3'd4;
  localparam logic [2:0] c_ST_ERROR  = 3'd5;

  localparam logic [1:0] c_ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] c_ERR_NOSYNC  = 2'b10;
  localparam logic [1:0] c_ERR_ZEROLEN = 2'b11;

  logic [2:0]           r_state;
  logic [2:0]           w_next_state;
  logic [LEN_W-1:0]     r_length;
  logic [LEN_W-1:0]     r_consumed;
  logic [LEN_W-1:0]     r_words_written;
  logic [c_IDLE_W-1:0]  r_idle_cnt;
  logic [c_FLUSH_W-1:0] r_flush_cnt;
  logic                 r_icap_csib;
  logic [31:0]          r_icap_i;
  logic                 r_error;
  logic [1:0]           r_err_code;

  logic                 w_s_ready;
  logic                 w_accept;
  logic                 w_is_sync;
  logic                 w_last;
  logic                 w_timeout;
  logic                 w_flush_last;
  logic                 w_busy;
  logic                 w_done;
  logic                 w_write;
  logic                 w_stream_write;
  logic [31:0]          w_wdata;
  logic [31:0]          w_wdata_sw;
  logic                 w_err_load;
  logic [1:0]           w_err_val;

  // Handshake depends on state only, so it is free of input-to-output paths.
  assign w_s_ready    = (r_state == c_ST_HUNT) || (r_state == c_ST_STREAM);
  assign w_accept     = s_valid && w_s_ready;
  assign w_is_sync    = (s_data == SYNC_WORD);
  assign w_last       = ((r_consumed + LEN_W'(1)) == r_length);
  assign w_timeout    = !w_accept && (r_idle_cnt == c_IDLE_W'(TIMEOUT_CYCLES - 1));
  assign w_flush_last = (r_flush_cnt == c_FLUSH_W'(FLUSH_NOOPS - 1));

  // ICAPE2 expects configuration bytes bit-reversed relative to the file order.
  generate
    if (BITSWAP != 0) begin : g_swap_on
      for (genvar b = 0; b < 4; b++) begin : g_byte
        for (genvar i = 0; i < 8; i++) begin : g_bit
          assign w_wdata_sw[8*b + i] = w_wdata[8*b + 7 - i];
        end
      end
    end else begin : g_swap_off
      assign w_wdata_sw = w_wdata;
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (start) begin
          w_next_state = (length_words == '0) ? c_ST_ERROR : c_ST_HUNT;
        end
      end
      c_ST_HUNT: begin
        if (w_accept) begin
          if (w_is_sync) begin
            w_next_state = w_last ? c_ST_FLUSH : c_ST_STREAM;
          end else if (w_last) begin
            w_next_state = c_ST_ERROR;
          end
        end else if (w_timeout) begin
          w_next_state = c_ST_ERROR;
        end
      end
      c_ST_STREAM: begin
        if (w_accept) begin
          if (w_last) begin
            w_next_state = c_ST_FLUSH;
          end
        end else if (w_timeout) begin
          w_next_state = c_ST_ERROR;
        end
      end
      c_ST_FLUSH: begin
        if ((FLUSH_NOOPS == 0) || w_flush_last) begin
          w_next_state = c_ST_DONE;
        end
      end
      c_ST_DONE:  w_next_state = c_ST_IDLE;
      c_ST_ERROR: w_next_state = c_ST_IDLE;
      default:    w_next_state = c_ST_IDLE;
    endcase
  end

  // Output / datapath-control logic
  always_comb begin
    w_busy         = 1'b0;
    w_done         = 1'b0;
    w_write        = 1'b0;
    w_stream_write = 1'b0;
    w_wdata        = s_data;
    w_err_load     = 1'b0;
    w_err_val      = 2'b00;
    case (r_state)
      c_ST_IDLE: begin
        if (start && (length_words == '0)) begin
          w_err_load = 1'b1;
          w_err_val  = c_ERR_ZEROLEN;
        end
      end
      c_ST_HUNT: begin
        w_busy         = 1'b1;
        w_write        = w_accept && w_is_sync;
        w_stream_write = w_accept && w_is_sync;
        if (w_accept && !w_is_sync && w_last) begin
          w_err_load = 1'b1;
          w_err_val  = c_ERR_NOSYNC;
        end else if (w_timeout) begin
          w_err_load = 1'b1;
          w_err_val  = c_ERR_TIMEOUT;
        end
      end
      c_ST_STREAM: begin
        w_busy         = 1'b1;
        w_write        = w_accept;
        w_stream_write = w_accept;
        if (w_timeout) begin
          w_err_load = 1'b1;
          w_err_val  = c_ERR_TIMEOUT;
        end
      end
      c_ST_FLUSH: begin
        w_busy  = 1'b1;
        w_write = (FLUSH_NOOPS != 0);
        w_wdata = c_NOOP;
      end
      c_ST_DONE: begin
        w_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_length        <= '0;
      r_consumed      <= '0;
      r_words_written <= '0;
      r_idle_cnt      <= '0;
      r_flush_cnt     <= '0;
      r_icap_csib     <= 1'b1;
      r_icap_i        <= '0;
      r_error         <= 1'b0;
      r_err_code      <= 2'b00;
    end else begin
      // One-cycle write latency; data holds when nothing is written.
      r_icap_csib <= !w_write;
      if (w_write) begin
        r_icap_i <= w_wdata_sw;
      end

      if ((r_state == c_ST_IDLE) && start && (length_words != '0)) begin
        r_length        <= length_words;
        r_consumed      <= '0;
        r_words_written <= '0;
        r_idle_cnt      <= '0;
        r_flush_cnt     <= '0;
        r_error         <= 1'b0;
        r_err_code      <= 2'b00;
      end

      if (w_s_ready) begin
        if (w_accept) begin
          r_consumed <= r_consumed + LEN_W'(1);
          r_idle_cnt <= '0;
        end else begin
          r_idle_cnt <= r_idle_cnt + c_IDLE_W'(1);
        end
      end

      if (w_stream_write) begin
        r_words_written <= r_words_written + LEN_W'(1);
      end

      if (r_state == c_ST_FLUSH) begin
        r_flush_cnt <= r_flush_cnt + c_FLUSH_W'(1);
      end

      if (w_err_load) begin
        r_error    <= 1'b1;
        r_err_code <= w_err_val;
      end
    end
  end

  assign s_ready       = w_s_ready;
  assign icap_csib     = r_icap_csib;
  assign icap_rdwrb    = 1'b0;
  assign icap_i        = r_icap_i;
  assign busy          = w_busy;
  assign done          = w_done;
  assign error         = r_error;
  assign err_code      = r_err_code;
  assign words_written = r_words_written;

endmodule
`default_nettype wire
